// File: rtl/tzd_et_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tzd_et_ctrl
// Brief    : Multi-channel early-termination controller. Captures NCH operands,
//            finds their common trailing-zero count and streams 2^(WIDTH-tz)
//            sample indices with valid/ready backpressure.
//            Optional macro TZD_ET_STATIC_TRUNC_EN adds a static truncation
//            input (trunc) whose set bits are discarded from the operands.
// Revision : 1.0 - initial release
// ============================================================================
module tzd_et_ctrl #(
   parameter int WIDTH = 8,
   parameter int NCH   = 2,
   localparam int TZW  = $clog2(WIDTH + 1)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [NCH*WIDTH-1:0] bx,
`ifdef TZD_ET_STATIC_TRUNC_EN
   input  logic [WIDTH-1:0]     trunc,
`endif
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [WIDTH-1:0]     out_idx,
   output logic                 out_last,
   output logic [TZW-1:0]       tz,
   output logic [WIDTH-1:0]     mask
);

   localparam logic [WIDTH:0]   c_one   = {{WIDTH{1'b0}}, 1'b1};
   localparam logic [TZW-1:0]   c_width = TZW'(WIDTH);

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   state_t           r_state, w_state_nxt;
   logic [WIDTH-1:0] r_cnt, w_cnt_nxt;
   logic [WIDTH-1:0] r_mask, w_mask_nxt;
   logic [TZW-1:0]   r_tz, w_tz_nxt;

   logic [WIDTH-1:0] w_orv;
   logic [WIDTH-1:0] w_mask_calc;
   logic [TZW-1:0]   w_tz_calc;
   logic [TZW-1:0]   w_shamt;
   logic [WIDTH:0]   w_len_m1;
   logic             w_last;

   // Combined operand, optionally with the statically truncated LSBs removed
   always_comb begin
      w_orv = '0;
      for (int c = 0; c < NCH; c++) begin
         w_orv = w_orv | bx[c*WIDTH +: WIDTH];
      end
`ifdef TZD_ET_STATIC_TRUNC_EN
      w_orv = w_orv & ~trunc;
`endif
   end

   // Thermometer mask of trailing zeros and its popcount
   always_comb begin
      logic m;
      m           = 1'b1;
      w_mask_calc = '0;
      w_tz_calc   = '0;
      for (int i = 0; i < WIDTH; i++) begin
         m              = m & ~w_orv[i];
         w_mask_calc[i] = m;
         w_tz_calc      = w_tz_calc + TZW'(m);
      end
   end

   // L-1 in WIDTH+1 bits so that L = 2^WIDTH needs no special case
   assign w_shamt  = c_width - r_tz;
   assign w_len_m1 = (c_one << w_shamt) - c_one;
   assign w_last   = (r_state == S_RUN) && ({1'b0, r_cnt} == w_len_m1);

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_tz_nxt    = r_tz;
      w_mask_nxt  = r_mask;
      case (r_state)
         S_IDLE: begin
            if (in_valid) begin
               w_state_nxt = S_RUN;
               w_cnt_nxt   = '0;
               w_tz_nxt    = w_tz_calc;
               w_mask_nxt  = w_mask_calc;
            end
         end
         S_RUN: begin
            if (out_ready) begin
               if (w_last) begin
                  w_state_nxt = S_IDLE;
                  w_cnt_nxt   = '0;
               end else begin
                  w_cnt_nxt   = r_cnt + 1'b1;
               end
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_tz    <= '0;
         r_mask  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_tz    <= w_tz_nxt;
         r_mask  <= w_mask_nxt;
      end
   end

   assign in_ready  = (r_state == S_IDLE);
   assign out_valid = (r_state == S_RUN);
   assign out_idx   = r_cnt;
   assign out_last  = w_last;
   assign tz        = r_tz;
   assign mask      = r_mask;

endmodule
`default_nettype wire

// File: tb/tb_tzd_et_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_tzd_et_ctrl
// Brief    : Directed self-checking bench for tzd_et_ctrl (WIDTH=8, NCH=2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_tzd_et_ctrl;

   localparam int WIDTH = 8;
   localparam int NCH   = 2;
   localparam int TZW   = 4;

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic                 in_valid;
   logic                 in_ready;
   logic [NCH*WIDTH-1:0] bx;
   logic                 out_valid;
   logic                 out_ready;
   logic [WIDTH-1:0]     out_idx;
   logic                 out_last;
   logic [TZW-1:0]       tz;
   logic [WIDTH-1:0]     mask;
`ifdef TZD_ET_STATIC_TRUNC_EN
   logic [WIDTH-1:0]     trunc;
`endif

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   tzd_et_ctrl #(.WIDTH(WIDTH), .NCH(NCH)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .bx        (bx),
`ifdef TZD_ET_STATIC_TRUNC_EN
      .trunc     (trunc),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_idx   (out_idx),
      .out_last  (out_last),
      .tz        (tz),
      .mask      (mask)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One full run: capture v, expect tz/mask and len beats; optional stall and
   // an ignored in_valid held high during the run
   task automatic run(input logic [15:0] v, input int etz, input logic [7:0] emask,
                      input int len, input int stall_at, input int stall_n, input bit hold_iv);
      check("idle_in_ready", 32'(in_ready), 32'd1);
      check("idle_out_valid", 32'(out_valid), 32'd0);
      bx       = v;
      in_valid = 1'b1;
      step();
      if (hold_iv) bx = 16'h0101;
      else         in_valid = 1'b0;
      check("cap_tz", 32'(tz), 32'(etz));
      check("cap_mask", 32'(mask), 32'(emask));
      check("run_in_ready", 32'(in_ready), 32'd0);
      for (int i = 0; i < len; i++) begin
         check("beat_valid", 32'(out_valid), 32'd1);
         check("beat_idx", 32'(out_idx), 32'(i));
         check("beat_last", 32'(out_last), 32'(i == len - 1));
         if (i == stall_at) begin
            out_ready = 1'b0;
            for (int s = 0; s < stall_n; s++) begin
               step();
               check("stall_valid", 32'(out_valid), 32'd1);
               check("stall_idx", 32'(out_idx), 32'(i));
            end
            out_ready = 1'b1;
         end
         if (i == len - 1) in_valid = 1'b0;
         step();
      end
      check("end_valid", 32'(out_valid), 32'd0);
      check("end_in_ready", 32'(in_ready), 32'd1);
      check("end_tz", 32'(tz), 32'(etz));
      check("end_mask", 32'(mask), 32'(emask));
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      bx        = '0;
`ifdef TZD_ET_STATIC_TRUNC_EN
      trunc     = '0;
`endif
      #2;
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_idx", 32'(out_idx), 32'd0);
      check("rst_out_last", 32'(out_last), 32'd0);
      check("rst_tz", 32'(tz), 32'd0);
      check("rst_mask", 32'(mask), 32'd0);
      step();
      step();
      rst_n = 1'b1;
      step();

      // OR=0x50 -> tz=4, L=16
      run(16'h4010, 4, 8'h0F, 16, -1, 0, 1'b0);
      // bit0 set -> tz=0, full 256-beat run
      run(16'h0001, 0, 8'h00, 256, -1, 0, 1'b0);
      // all zero -> tz=8, single beat
      run(16'h0000, 8, 8'hFF, 1, -1, 0, 1'b0);
      // 0x20 -> tz=5, L=8, 3-cycle stall at idx 3, in_valid held during run
      run(16'h0020, 5, 8'h1F, 8, 3, 3, 1'b1);
      // 0x80 -> tz=7, L=2
      run(16'h8000, 7, 8'h7F, 2, -1, 0, 1'b0);

      // Asynchronous reset in the middle of an L=16 run
      bx       = 16'h4010;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      for (int i = 0; i < 5; i++) step();
      check("pre_rst_idx", 32'(out_idx), 32'd5);
      rst_n = 1'b0;
      #1;
      check("mid_rst_valid", 32'(out_valid), 32'd0);
      check("mid_rst_idx", 32'(out_idx), 32'd0);
      check("mid_rst_last", 32'(out_last), 32'd0);
      check("mid_rst_tz", 32'(tz), 32'd0);
      check("mid_rst_mask", 32'(mask), 32'd0);
      check("mid_rst_in_ready", 32'(in_ready), 32'd1);
      step();
      rst_n = 1'b1;
      step();
      run(16'h4010, 4, 8'h0F, 16, -1, 0, 1'b0);

`ifdef TZD_ET_STATIC_TRUNC_EN
      // OR=0x41: trunc=0x3F leaves 0x40 -> tz=6, L=4; trunc=0 -> tz=0, L=256
      trunc = 8'h3F;
      run(16'h4100, 6, 8'h3F, 4, -1, 0, 1'b0);
      trunc = 8'h00;
      run(16'h4100, 0, 8'h00, 256, -1, 0, 1'b0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
